// File: rtl/nrom_cart_if.sv
// Bus bundle between an NROM cartridge and the image loader / CPU / PPU decoders.
// The cart side uses the slave modport; the system side drives through master.
interface nrom_cart_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       cart_ready;
  logic       load_err;
  logic       mirror_v;

  logic [15:0] cpu_ab;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        cpu_hit;

  logic [13:0] ppu_ab;
  logic        ppu_rd;
  logic        ppu_wr;
  logic [7:0]  ppu_di;
  logic [7:0]  ppu_do;
  logic        ppu_hit;

  modport master (
    output load_valid, load_data, cpu_ab, cpu_rd, cpu_wr, cpu_di,
           ppu_ab, ppu_rd, ppu_wr, ppu_di,
    input  load_ready, cart_ready, load_err, mirror_v,
           cpu_do, cpu_hit, ppu_do, ppu_hit
  );

  modport slave (
    input  load_valid, load_data, cpu_ab, cpu_rd, cpu_wr, cpu_di,
           ppu_ab, ppu_rd, ppu_wr, ppu_di,
    output load_ready, cart_ready, load_err, mirror_v,
           cpu_do, cpu_hit, ppu_do, ppu_hit
  );
endinterface

// File: rtl/nrom_cart.sv
// NROM-family cartridge: parses a streamed iNES image into PRG/CHR memory,
// then serves the CPU and PPU buses with registered, one-cycle-latency reads.
module nrom_cart #(
  parameter int PRG_BANKS_MAX = 2,
  parameter int CHR_BANKS_MAX = 1,
  parameter int PRG_RAM_BYTES = 8192,
  parameter int CHR_RAM_BYTES = 8192
) (
  input logic        cpu_clk,
  input logic        rst_n,
  nrom_cart_if.slave bus
);

  localparam int PRG_ROM_BYTES = PRG_BANKS_MAX * 16384;
  localparam int CHR_ROM_BYTES = CHR_BANKS_MAX * 8192;
  localparam int CHR_MEM_BYTES = (CHR_ROM_BYTES > CHR_RAM_BYTES) ? CHR_ROM_BYTES : CHR_RAM_BYTES;
  localparam int RAM_DEPTH     = (PRG_RAM_BYTES > 0) ? PRG_RAM_BYTES : 1;
  localparam int PA            = $clog2(PRG_ROM_BYTES);
  localparam int CA            = $clog2(CHR_MEM_BYTES);
  localparam int RA            = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam bit HAS_RAM       = (PRG_RAM_BYTES > 0);

  typedef enum logic [2:0] {HDR, TRN, PRG, CHR, RUN, ERR} state_t;

  state_t      r_state, w_next;
  logic [20:0] r_cnt;
  logic        r_prg256, r_trainer, r_mirrorV, r_chrIsRam;
  logic [7:0]  r_chrUnits;
  logic [7:0]  r_cpuDo, r_ppuDo;
  logic        r_cpuHit, r_ppuHit;

  // CHR ROM and CHR RAM never coexist, so they share one array.
  logic [7:0] r_prgRom [PRG_ROM_BYTES];
  logic [7:0] r_chrMem [CHR_MEM_BYTES];
  logic [7:0] r_prgRam [RAM_DEPTH];

  logic          w_loadReady, w_accept, w_hdrBad, w_run;
  logic [20:0]   w_prgLast, w_chrLast;
  logic          w_cpuRom, w_cpuRam, w_ppuChr;
  logic [PA-1:0] w_prgIdx;
  logic [RA-1:0] w_ramIdx;
  logic [CA-1:0] w_chrIdx;

  assign w_loadReady = (r_state == HDR) || (r_state == TRN) || (r_state == PRG) || (r_state == CHR);
  assign w_accept    = rst_n && bus.load_valid && w_loadReady;
  assign w_run       = (r_state == RUN);
  assign w_prgLast   = r_prg256 ? 21'd32767 : 21'd16383;
  assign w_chrLast   = {r_chrUnits - 8'd1, 13'h1FFF};

  assign w_cpuRom = bus.cpu_ab[15];
  assign w_cpuRam = HAS_RAM && (bus.cpu_ab[15:13] == 3'b011);
  assign w_ppuChr = !bus.ppu_ab[13];
  assign w_prgIdx = r_prg256 ? PA'(bus.cpu_ab[14:0]) : PA'(bus.cpu_ab[13:0]);
  assign w_ramIdx = RA'(bus.cpu_ab & 16'(RAM_DEPTH - 1));
  assign w_chrIdx = r_chrIsRam ? CA'(21'(bus.ppu_ab) & 21'(CHR_RAM_BYTES - 1))
                               : CA'(bus.ppu_ab[12:0]);

  assign bus.load_ready = w_loadReady;
  assign bus.cart_ready = w_run;
  assign bus.load_err   = (r_state == ERR);
  assign bus.mirror_v   = r_mirrorV;
  assign bus.cpu_do     = r_cpuDo;
  assign bus.cpu_hit    = r_cpuHit;
  assign bus.ppu_do     = r_ppuDo;
  assign bus.ppu_hit    = r_ppuHit;

  // Header byte validation, indexed by the position within the 16-byte header.
  always_comb begin
    w_hdrBad = 1'b0;
    case (r_cnt[3:0])
      4'd0:       w_hdrBad = (bus.load_data != 8'h4E);
      4'd1:       w_hdrBad = (bus.load_data != 8'h45);
      4'd2:       w_hdrBad = (bus.load_data != 8'h53);
      4'd3:       w_hdrBad = (bus.load_data != 8'h1A);
      4'd4:       w_hdrBad = (bus.load_data == 8'd0) || (bus.load_data > 8'(PRG_BANKS_MAX));
      4'd5:       w_hdrBad = (bus.load_data > 8'(CHR_BANKS_MAX));
      4'd6, 4'd7: w_hdrBad = (bus.load_data[7:4] != 4'd0);
      default:    w_hdrBad = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR: if (w_accept) begin
             if (w_hdrBad)                w_next = ERR;
             else if (r_cnt[3:0] == 4'hF) w_next = r_trainer ? TRN : PRG;
           end
      TRN: if (w_accept && r_cnt == 21'd511) w_next = PRG;
      PRG: if (w_accept && r_cnt == w_prgLast) w_next = (r_chrUnits != 8'd0) ? CHR : RUN;
      CHR: if (w_accept && r_cnt == w_chrLast) w_next = RUN;
      default: w_next = r_state;
    endcase
  end

  // The byte counter restarts on every state change so each phase counts from zero.
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      r_state    <= HDR;
      r_cnt      <= '0;
      r_prg256   <= 1'b0;
      r_trainer  <= 1'b0;
      r_mirrorV  <= 1'b0;
      r_chrUnits <= '0;
      r_chrIsRam <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_accept)     r_cnt <= r_cnt + 21'd1;
      if (w_accept && r_state == HDR) begin
        case (r_cnt[3:0])
          4'd4: r_prg256   <= (bus.load_data == 8'd2);
          4'd5: r_chrUnits <= bus.load_data;
          4'd6: begin
            r_mirrorV <= bus.load_data[0];
            r_trainer <= bus.load_data[2];
          end
          default: ;
        endcase
      end
      if (r_state == PRG && w_next == RUN) r_chrIsRam <= 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (w_accept && r_state == PRG) r_prgRom[r_cnt[PA-1:0]] <= bus.load_data;
  end

  always_ff @(posedge cpu_clk) begin
    if (w_accept && r_state == CHR)
      r_chrMem[r_cnt[CA-1:0]] <= bus.load_data;
    else if (rst_n && w_run && r_chrIsRam && bus.ppu_wr && w_ppuChr)
      r_chrMem[w_chrIdx] <= bus.ppu_di;
  end

  always_ff @(posedge cpu_clk) begin
    if (rst_n && w_run && bus.cpu_wr && w_cpuRam) r_prgRam[w_ramIdx] <= bus.cpu_di;
  end

  // Read ports only update on a strobe; otherwise the last result is held.
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      r_cpuDo  <= '0;
      r_cpuHit <= 1'b0;
    end else if (bus.cpu_rd) begin
      if (w_run && w_cpuRom) begin
        r_cpuDo  <= r_prgRom[w_prgIdx];
        r_cpuHit <= 1'b1;
      end else if (w_run && w_cpuRam) begin
        r_cpuDo  <= r_prgRam[w_ramIdx];
        r_cpuHit <= 1'b1;
      end else begin
        r_cpuDo  <= '0;
        r_cpuHit <= 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      r_ppuDo  <= '0;
      r_ppuHit <= 1'b0;
    end else if (bus.ppu_rd) begin
      if (w_run && w_ppuChr) begin
        r_ppuDo  <= r_chrMem[w_chrIdx];
        r_ppuHit <= 1'b1;
      end else begin
        r_ppuDo  <= '0;
        r_ppuHit <= 1'b0;
      end
    end
  end

endmodule
